// File: rtl/key_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// key_conditioner_pkg
// Shared definitions for the player-button conditioner:
//   - chan_state_e : per-channel FSM state encoding
//   - DEFAULT_DEBOUNCE_CYCLES / DEFAULT_COOLDOWN_CYCLES : parameter defaults
//   - CNT_W        : width of the per-channel debounce/cooldown counter
//   - sat_inc()    : saturating counter increment
// -----------------------------------------------------------------------------
package key_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,  // released, waiting for a low level
        ST_DB_DN = 3'd1,  // qualifying a press
        ST_HELD  = 3'd2,  // press accepted, key still down
        ST_DB_UP = 3'd3,  // qualifying a release
        ST_COOL  = 3'd4   // post-release lockout, input ignored
    } chan_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 20;
    localparam int DEFAULT_COOLDOWN_CYCLES = 40;
    localparam int CNT_W                   = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/key_conditioner_chan.sv
// -----------------------------------------------------------------------------
// key_chan
// One button channel: two-flop synchronizer, debounce/cooldown FSM and its
// saturating counter. All outputs are registered.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   key_n_i   : raw asynchronous button, active-low
//   press_n_o : one-cycle strobe (low) in the cycle the channel enters HELD
//   level_n_o : debounced level, low in HELD and DB_UP
// -----------------------------------------------------------------------------
module key_chan
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_n_o,
    output logic level_n_o
);

    localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CD_LIM = CNT_W'(COOLDOWN_CYCLES);

    logic [1:0]       sync_q;
    logic             s;
    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             level_q, level_d;

    // Synchronized key level; every decision below uses only this.
    assign s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_DB_DN;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DB_DN: begin
                if (s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LIM) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    press_d = 1'b0;   // the only place a strobe is generated
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_HELD: begin
                if (s) begin
                    state_d = ST_DB_UP;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DB_UP: begin
                if (!s) begin
                    // Release glitch: back to HELD without a new strobe.
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LIM) begin
                    state_d = (COOLDOWN_CYCLES == 0) ? ST_IDLE : ST_COOL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_COOL: begin
                // Counter starts at 0 on entry; leave once it has reached the limit.
                if (cnt_q >= CD_LIM) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = !((state_d == ST_HELD) || (state_d == ST_DB_UP));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            level_q <= level_d;
        end
    end

    assign press_n_o = press_q;
    assign level_n_o = level_q;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Two-player button conditioner: one independent key_chan per player plus a
// coincidence flag.
// Ports:
//   clk      : system clock (100 Hz game clock)
//   rst      : asynchronous active-low reset
//   key_n    : raw buttons, active-low; bit0 player 1, bit1 player 2
//   press_n  : one-cycle hit strobes, active-low
//   level_n  : debounced levels, active-low
//   both_hit : high in a cycle where both strobes are low together
// -----------------------------------------------------------------------------
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_n,
    output logic [1:0] press_n,
    output logic [1:0] level_n,
    output logic       both_hit
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            key_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .key_n_i   (key_n[gi]),
                .press_n_o (press_n[gi]),
                .level_n_o (level_n[gi])
            );
        end
    endgenerate

    // Strobes are registered, so this decode is glitch-free and clears
    // immediately with reset.
    assign both_hit = ~press_n[0] & ~press_n[1];

endmodule
